// File: rtl/branch_predict_unit.sv
// Branch resolution and bimodal prediction unit.
// A table of 2-bit saturating counters, indexed by word-aligned PC bits,
// gives a combinational taken/not-taken prediction at fetch. Resolve
// requests compute the real branch outcome, the mispredict flag and the
// correct next PC, all registered one cycle after acceptance. Statistics
// counters saturate at all-ones.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [2:0]      funct3,
    input  logic            branch,
    input  logic            jump,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_target,
    input  logic            flush,
    output logic            out_valid,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic             out_valid_q, out_valid_d;
    logic             out_taken_q, out_taken_d;
    logic             out_mispredict_q, out_mispredict_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic             accept;
    logic             cond_taken;
    logic             taken;
    logic             mispredict;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;

    assign lookup_idx = lookup_pc[2 +: IDX_W];
    assign upd_idx    = res_pc[2 +: IDX_W];

    // Prediction reads the registered table, so a same-cycle update is not visible yet.
    assign pred_taken = bht_q[lookup_idx][1];

    assign accept = res_valid & ~flush;

    // Conditional-branch outcome from the B-type funct3 encoding.
    always_comb begin
        cond_taken = 1'b0;
        unique case (funct3)
            3'b000:  cond_taken = (rs1_data == rs2_data);
            3'b001:  cond_taken = (rs1_data != rs2_data);
            3'b100:  cond_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond_taken = (rs1_data <  rs2_data);
            3'b111:  cond_taken = (rs1_data >= rs2_data);
            default: cond_taken = 1'b0;
        endcase
    end

    // Jumps always redirect and override the branch flag.
    assign taken      = jump | (branch & cond_taken);
    assign mispredict = taken ^ res_pred_taken;

    // Next-state for result registers, counter table and statistics.
    always_comb begin
        out_valid_d        = accept;
        out_taken_d        = 1'b0;
        out_mispredict_d   = 1'b0;
        redirect_pc_d      = '0;
        bht_d              = bht_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (accept) begin
            out_taken_d      = taken;
            out_mispredict_d = mispredict;
            redirect_pc_d    = taken ? res_target : res_pc + XLEN'(4);

            if (branch && !jump) begin
                if (cond_taken) begin
                    if (bht_q[upd_idx] != 2'b11) begin
                        bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
                    end
                end else begin
                    if (bht_q[upd_idx] != 2'b00) begin
                        bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
                    end
                end
            end

            if ((branch || jump) && (branch_count_q != '1)) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end
            if (mispredict && (mispredict_count_q != '1)) begin
                mispredict_count_d = mispredict_count_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset leaves every counter weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            out_valid_q        <= 1'b0;
            out_taken_q        <= 1'b0;
            out_mispredict_q   <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            out_valid_q        <= out_valid_d;
            out_taken_q        <= out_taken_d;
            out_mispredict_q   <= out_mispredict_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_taken        = out_taken_q;
    assign out_mispredict   = out_mispredict_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: stimulus pushes expected results
// into a queue, a negedge monitor pops and compares whenever out_valid is seen.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [2:0]  funct3;
    logic        branch;
    logic        jump;
    logic        res_pred_taken;
    logic [31:0] res_target;
    logic        flush;
    logic        out_valid;
    logic        out_taken;
    logic        out_mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  branch_count;
    logic [3:0]  mispredict_count;

    branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_pc        (lookup_pc),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .funct3           (funct3),
        .branch           (branch),
        .jump             (jump),
        .res_pred_taken   (res_pred_taken),
        .res_target       (res_target),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_taken        (out_taken),
        .out_mispredict   (out_mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        int          due;
        logic        taken;
        logic        mis;
        logic [31:0] redir;
        logic [3:0]  bc;
        logic [3:0]  mc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] exp_bc = 4'd0;
    logic [3:0] exp_mc = 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented result against the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("latency_cycle", cyc, e.due);
                chk("out_taken", {31'd0, out_taken}, {31'd0, e.taken});
                chk("out_mispredict", {31'd0, out_mispredict}, {31'd0, e.mis});
                chk("redirect_pc", redirect_pc, e.redir);
                chk("branch_count", {28'd0, branch_count}, {28'd0, e.bc});
                chk("mispredict_count", {28'd0, mispredict_count}, {28'd0, e.mc});
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("missing_out_valid", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res_valid = 1'b0;
        flush     = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        step();
    endtask

    task automatic drive_req(input logic br, input logic jp, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pc, input logic [31:0] tgt,
                             input logic pred, input logic e_tk, input logic e_mis,
                             input logic [31:0] e_red);
        exp_t e;
        res_valid      = 1'b1;
        flush          = 1'b0;
        branch         = br;
        jump           = jp;
        funct3         = f3;
        rs1_data       = a;
        rs2_data       = b;
        res_pc         = pc;
        res_target     = tgt;
        res_pred_taken = pred;
        if ((br || jp) && exp_bc != 4'hF) exp_bc = exp_bc + 4'd1;
        if (e_mis && exp_mc != 4'hF) exp_mc = exp_mc + 4'd1;
        e.due   = cyc + 1;
        e.taken = e_tk;
        e.mis   = e_mis;
        e.redir = e_red;
        e.bc    = exp_bc;
        e.mc    = exp_mc;
        sb.push_back(e);
    endtask

    task automatic req(input logic br, input logic jp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic e_tk, input logic e_mis,
                       input logic [31:0] e_red);
        drive_req(br, jp, f3, a, b, pc, tgt, pred, e_tk, e_mis, e_red);
        step();
    endtask

    task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
        lookup_pc = pc;
        #1;
        chk(name, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b0; lookup_pc = 32'h0; res_valid = 1'b0; res_pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; funct3 = 3'b000; branch = 1'b0;
        jump = 1'b0; res_pred_taken = 1'b0; res_target = 32'h0; flush = 1'b0;
        #2 rst = 1'b1;

        // Reset state; a request held during reset is ignored.
        res_valid = 1'b1; branch = 1'b1; rs1_data = 32'd5; rs2_data = 32'd5; res_pc = 32'h100;
        repeat (3) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_taken", {31'd0, out_taken}, 32'd0);
        chk("rst_out_mispredict", {31'd0, out_mispredict}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_branch_count", {28'd0, branch_count}, 32'd0);
        chk("rst_mispredict_count", {28'd0, mispredict_count}, 32'd0);
        chk_pred("rst_pred_0x0", 32'h0, 1'b0);
        chk_pred("rst_pred_0x100", 32'h100, 1'b0);
        chk_pred("rst_pred_0xfffffffc", 32'hFFFF_FFFC, 1'b0);
        res_valid = 1'b0; branch = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Counter training at 0x100 with same-cycle read-before-write.
        lookup_pc = 32'h100;
        drive_req(1, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h180, 0, 1, 1, 32'h180);
        chk_pred("pred_same_cycle_update", 32'h100, 1'b0);
        step();
        chk_pred("pred_after_first_taken", 32'h100, 1'b1);
        req(1, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h180, 1, 1, 0, 32'h180);
        req(1, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h180, 1, 1, 0, 32'h180);
        req(1, 0, 3'b000, 32'd5, 32'd6, 32'h100, 32'h180, 1, 0, 1, 32'h104);
        chk_pred("pred_sat_high_then_dec", 32'h100, 1'b1);
        req(1, 0, 3'b000, 32'd5, 32'd6, 32'h100, 32'h180, 0, 0, 0, 32'h104);
        chk_pred("pred_back_to_weak_nt", 32'h100, 1'b0);
        idle();

        // Compare types, back-to-back.
        req(1, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h200, 0, 1, 1, 32'h200);
        req(1, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h200, 0, 0, 0, 32'h304);
        req(1, 0, 3'b101, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'h400, 1, 1, 0, 32'h400);
        req(1, 0, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'h400, 1, 0, 1, 32'h304);
        req(1, 0, 3'b001, 32'd3, 32'd3, 32'h300, 32'h400, 0, 0, 0, 32'h304);
        req(1, 0, 3'b010, 32'd3, 32'd3, 32'h300, 32'h400, 0, 0, 0, 32'h304);
        req(0, 0, 3'b000, 32'd3, 32'd3, 32'h300, 32'h400, 1, 0, 1, 32'h304);
        req(1, 0, 3'b001, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h400, 0, 0, 0, 32'h0);
        idle();

        // Jumps leave the table alone; jump wins over branch.
        req(0, 1, 3'b000, 32'd0, 32'd0, 32'h108, 32'h500, 0, 1, 1, 32'h500);
        idle();
        chk_pred("jal_no_bht_update", 32'h108, 1'b0);
        req(1, 1, 3'b001, 32'd3, 32'd3, 32'h10C, 32'h600, 0, 1, 1, 32'h600);
        req(1, 1, 3'b001, 32'd3, 32'd3, 32'h10C, 32'h600, 0, 1, 1, 32'h600);
        idle();
        chk_pred("branch_jump_no_bht_update", 32'h10C, 1'b0);

        // Flushed and invalid requests are ignored.
        res_valid = 1'b1; flush = 1'b1; branch = 1'b1; jump = 1'b0; funct3 = 3'b000;
        rs1_data = 32'd5; rs2_data = 32'd5; res_pc = 32'h110; res_pred_taken = 1'b0;
        step();
        res_valid = 1'b0; flush = 1'b0;
        step();
        idle();
        chk("flush_branch_count", {28'd0, branch_count}, {28'd0, exp_bc});
        chk("flush_mispredict_count", {28'd0, mispredict_count}, {28'd0, exp_mc});
        chk_pred("flush_no_bht_update", 32'h110, 1'b0);

        // Reset mid-operation discards the in-flight result.
        res_valid = 1'b1; branch = 1'b1; res_pc = 32'h120; funct3 = 3'b000;
        rs1_data = 32'd1; rs2_data = 32'd1; res_target = 32'h700; res_pred_taken = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        step();
        res_valid = 1'b0; branch = 1'b0;
        rst = 1'b0;
        exp_bc = 4'd0; exp_mc = 4'd0;
        @(negedge clk);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_branch_count", {28'd0, branch_count}, 32'd0);
        chk_pred("release_pred_0x100", 32'h100, 1'b0);
        step();
        chk("release_out_valid_2", {31'd0, out_valid}, 32'd0);

        // Twenty mispredicted branches back-to-back saturate both counters.
        for (int i = 0; i < 20; i++) begin
            req(1, 0, 3'b000, 32'd7, 32'd7, 32'h200, 32'h240, 0, 1, 1, 32'h240);
        end
        idle();
        chk("sat_branch_count", {28'd0, branch_count}, 32'd15);
        chk("sat_mispredict_count", {28'd0, mispredict_count}, 32'd15);

        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
